// File: rtl/core_types_pkg.sv
// Shared core types and sizing constants for the PRF write-port arbiter.
// Contents:
//   - requester / bank / register-file sizing constants
//   - prf_wr_req_t : one writeback request {valid, PR, data}
//   - popcount_wr  : population count over a requester-wide vector
package core_types_pkg;

    localparam int PRF_WR_COUNT       = 8;
    localparam int LOG_PRF_WR_COUNT   = $clog2(PRF_WR_COUNT);
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
    localparam int PR_COUNT           = 128;
    localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
    localparam int XLEN               = 32;

    // Bank-local index width: PR bits above the bank-select bits.
    localparam int BANK_ADDR_W        = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    typedef struct packed {
        logic                    valid;
        logic [LOG_PR_COUNT-1:0] PR;
        logic [XLEN-1:0]         data;
    } prf_wr_req_t;

    function automatic logic [LOG_PRF_WR_COUNT:0] popcount_wr(input logic [PRF_WR_COUNT-1:0] vec);
        logic [LOG_PRF_WR_COUNT:0] cnt;
        cnt = {(LOG_PRF_WR_COUNT+1){1'b0}};
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            cnt = cnt + {{LOG_PRF_WR_COUNT{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prf_wr_bank_rr_arb.sv
// Combinational round-robin arbiter for a single PRF bank.
// The winner is the first requesting index at or after rr_ptr, searching
// upward and wrapping from PRF_WR_COUNT-1 to 0. The pointer register lives
// in the parent; this block only proposes the next value.
// Ports:
//   req      in  [PRF_WR_COUNT-1:0]     requesters targeting this bank
//   rr_ptr   in  [LOG_PRF_WR_COUNT-1:0] current round-robin pointer
//   grant    out [PRF_WR_COUNT-1:0]     one-hot winner (zero when idle)
//   next_ptr out [LOG_PRF_WR_COUNT-1:0] winner+1 on a grant, else rr_ptr
module prf_wr_bank_rr_arb
    import core_types_pkg::*;
(
    input  logic [PRF_WR_COUNT-1:0]     req,
    input  logic [LOG_PRF_WR_COUNT-1:0] rr_ptr,
    output logic [PRF_WR_COUNT-1:0]     grant,
    output logic [LOG_PRF_WR_COUNT-1:0] next_ptr
);

    logic [2*PRF_WR_COUNT-1:0]   req_dbl_s;
    logic [PRF_WR_COUNT-1:0]     req_rot_s;
    logic                        found_s;
    logic [LOG_PRF_WR_COUNT-1:0] offset_s;
    logic [LOG_PRF_WR_COUNT-1:0] winner_s;

    // Rotate requests so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        req_dbl_s = {req, req};
        req_rot_s = PRF_WR_COUNT'(req_dbl_s >> rr_ptr);
        found_s   = 1'b0;
        offset_s  = {LOG_PRF_WR_COUNT{1'b0}};
        for (int k = 0; k < PRF_WR_COUNT; k++) begin
            if (!found_s && req_rot_s[k]) begin
                found_s  = 1'b1;
                offset_s = LOG_PRF_WR_COUNT'(k);
            end else begin
                found_s  = found_s;
            end
        end
        // PRF_WR_COUNT is a power of two, so the pointer-width add wraps modulo the count.
        winner_s = rr_ptr + offset_s;
        if (found_s) begin
            grant    = PRF_WR_COUNT'({{(PRF_WR_COUNT-1){1'b0}}, 1'b1} << winner_s);
            next_ptr = winner_s + LOG_PRF_WR_COUNT'(1);
        end else begin
            grant    = {PRF_WR_COUNT{1'b0}};
            next_ptr = rr_ptr;
        end
    end

endmodule

// File: rtl/prf_wr_arbiter.sv
// PRF bank write-port arbiter.
// Shares PRF_BANK_COUNT single-write banks among PRF_WR_COUNT writeback
// requesters. Bank = PR low bits, bank-local address = PR high bits. Each bank
// arbitrates round-robin; losers see WR_ready=0 and hold their request.
// Writes to PR 0 are accepted immediately and discarded (hardwired zero).
// Bank write outputs are registered (one cycle after the grant).
// Optional build macro: PRF_WR_ARB_PERF_EN adds perf_conflict_count.
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   WR_valid/PR/data_by_wr    per-requester write request
//   WR_ready_by_wr            combinational accept for this cycle
//   bank_WEN/waddr/wdata/wsrc_by_bank  registered per-bank write
//   perf_conflict_count       (PRF_WR_ARB_PERF_EN) saturating stall count
module prf_wr_arbiter
    import core_types_pkg::*;
(
    input  logic                                          CLK,
    input  logic                                          nRST,
    input  logic [PRF_WR_COUNT-1:0]                       WR_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]     WR_PR_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]             WR_data_by_wr,
    output logic [PRF_WR_COUNT-1:0]                       WR_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]                     bank_WEN_by_bank,
    output logic [PRF_BANK_COUNT-1:0][BANK_ADDR_W-1:0]    bank_waddr_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]           bank_wdata_by_bank,
    output logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]   bank_wsrc_by_bank
`ifdef PRF_WR_ARB_PERF_EN
    ,
    output logic [31:0]                                   perf_conflict_count
`endif
);

    prf_wr_req_t                          req_s [PRF_WR_COUNT];
    logic [PRF_WR_COUNT-1:0]              pr_zero_s;
    logic [PRF_WR_COUNT-1:0]              bank_req_s [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0]              grant_s    [PRF_BANK_COUNT];
    logic [LOG_PRF_WR_COUNT-1:0]          next_ptr_s [PRF_BANK_COUNT];
    logic [LOG_PRF_WR_COUNT-1:0]          rr_ptr_r   [PRF_BANK_COUNT];
    logic [BANK_ADDR_W-1:0]               win_addr_s [PRF_BANK_COUNT];
    logic [XLEN-1:0]                      win_data_s [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0]              granted_s;
    logic [PRF_WR_COUNT-1:0]              ready_s;

    // Gather each requester's port slices into one request record.
    always_comb begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            req_s[i].valid = WR_valid_by_wr[i];
            req_s[i].PR    = WR_PR_by_wr[i];
            req_s[i].data  = WR_data_by_wr[i];
        end
    end

    // Route each non-PR0 request to the bank selected by its PR low bits.
    always_comb begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            pr_zero_s[i] = (req_s[i].PR == LOG_PR_COUNT'(0));
        end
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            bank_req_s[b] = {PRF_WR_COUNT{1'b0}};
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                bank_req_s[b][i] = req_s[i].valid && !pr_zero_s[i] &&
                    (req_s[i].PR[LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank_arb
        prf_wr_bank_rr_arb u_arb (
            .req      (bank_req_s[b]),
            .rr_ptr   (rr_ptr_r[b]),
            .grant    (grant_s[b]),
            .next_ptr (next_ptr_s[b])
        );
    end

    // Accept granted requests and PR0 drops; nothing is accepted while in reset.
    always_comb begin
        granted_s = {PRF_WR_COUNT{1'b0}};
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            granted_s = granted_s | grant_s[b];
        end
        ready_s = {PRF_WR_COUNT{nRST}} & WR_valid_by_wr & (pr_zero_s | granted_s);
    end

    assign WR_ready_by_wr = ready_s;

    // One-hot AND-OR mux of the winning requester's address and data per bank.
    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            win_addr_s[b] = {BANK_ADDR_W{1'b0}};
            win_data_s[b] = {XLEN{1'b0}};
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                win_addr_s[b] = win_addr_s[b] |
                    ({BANK_ADDR_W{grant_s[b][i]}} & req_s[i].PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
                win_data_s[b] = win_data_s[b] | ({XLEN{grant_s[b][i]}} & req_s[i].data);
            end
        end
    end

    // Bank write register stage and round-robin pointer update.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                bank_WEN_by_bank[b]   <= 1'b0;
                bank_waddr_by_bank[b] <= {BANK_ADDR_W{1'b0}};
                bank_wdata_by_bank[b] <= {XLEN{1'b0}};
                bank_wsrc_by_bank[b]  <= {PRF_WR_COUNT{1'b0}};
                rr_ptr_r[b]           <= {LOG_PRF_WR_COUNT{1'b0}};
            end
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                bank_WEN_by_bank[b]  <= |grant_s[b];
                bank_wsrc_by_bank[b] <= grant_s[b];
                rr_ptr_r[b]          <= next_ptr_s[b];
                // Address and data are don't-care without a grant; hold to save toggles.
                if (|grant_s[b]) begin
                    bank_waddr_by_bank[b] <= win_addr_s[b];
                    bank_wdata_by_bank[b] <= win_data_s[b];
                end else begin
                    bank_waddr_by_bank[b] <= bank_waddr_by_bank[b];
                    bank_wdata_by_bank[b] <= bank_wdata_by_bank[b];
                end
            end
        end
    end

`ifdef PRF_WR_ARB_PERF_EN
    logic [PRF_WR_COUNT-1:0]     conflict_s;
    logic [LOG_PRF_WR_COUNT:0]   conflict_cnt_s;
    logic [32:0]                 perf_sum_s;
    logic [31:0]                 perf_r;

    // Count stalled (valid, not ready) requesters; PR0 writes never stall.
    always_comb begin
        conflict_s     = WR_valid_by_wr & ~ready_s & ~pr_zero_s;
        conflict_cnt_s = popcount_wr(conflict_s);
        perf_sum_s     = {1'b0, perf_r} + 33'(conflict_cnt_s);
    end

    // Saturating stall counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            perf_r <= 32'h0000_0000;
        end else if (perf_sum_s[32]) begin
            perf_r <= 32'hFFFF_FFFF;
        end else begin
            perf_r <= perf_sum_s[31:0];
        end
    end

    assign perf_conflict_count = perf_r;
`endif

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// Self-checking bench for prf_wr_arbiter: directed scenarios with hand-derived
// expectations, then randomized traffic against a distance-based reference model.
module tb_prf_wr_arbiter;
    import core_types_pkg::*;

    logic                                        CLK;
    logic                                        nRST;
    logic [PRF_WR_COUNT-1:0]                     wr_valid;
    logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]   wr_pr;
    logic [PRF_WR_COUNT-1:0][XLEN-1:0]           wr_data;
    logic [PRF_WR_COUNT-1:0]                     wr_ready;
    logic [PRF_BANK_COUNT-1:0]                   bank_wen;
    logic [PRF_BANK_COUNT-1:0][BANK_ADDR_W-1:0]  bank_waddr;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         bank_wdata;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] bank_wsrc;
`ifdef PRF_WR_ARB_PERF_EN
    logic [31:0]                                 perf_count;
`endif

    prf_wr_arbiter dut (
        .CLK                (CLK),
        .nRST               (nRST),
        .WR_valid_by_wr     (wr_valid),
        .WR_PR_by_wr        (wr_pr),
        .WR_data_by_wr      (wr_data),
        .WR_ready_by_wr     (wr_ready),
        .bank_WEN_by_bank   (bank_wen),
        .bank_waddr_by_bank (bank_waddr),
        .bank_wdata_by_bank (bank_wdata),
        .bank_wsrc_by_bank  (bank_wsrc)
`ifdef PRF_WR_ARB_PERF_EN
        ,
        .perf_conflict_count(perf_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int                      m_ptr   [PRF_BANK_COUNT];
    int                      m_win   [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0] m_ready;
    logic                    m_wen   [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0] m_wsrc  [PRF_BANK_COUNT];
    int                      m_waddr [PRF_BANK_COUNT];
    logic [XLEN-1:0]         m_wdata [PRF_BANK_COUNT];
    longint                  m_perf;

    task automatic clear_reqs();
        wr_valid = '0;
        wr_pr    = '0;
        wr_data  = '0;
    endtask

    task automatic set_req(input int i, input int pr, input logic [XLEN-1:0] d);
        wr_valid[i] = 1'b1;
        wr_pr[i]    = LOG_PR_COUNT'(pr);
        wr_data[i]  = d;
    endtask

    task automatic model_reset();
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            m_ptr[b] = 0; m_wen[b] = 1'b0; m_wsrc[b] = '0; m_waddr[b] = 0; m_wdata[b] = '0;
        end
        m_perf = 0;
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        clear_reqs();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();
    endtask

    // Winner per bank = candidate with the smallest cyclic distance from the pointer.
    task automatic model_eval();
        int bestd [PRF_BANK_COUNT];
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            m_win[b] = -1; bestd[b] = PRF_WR_COUNT;
        end
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            int pr, b, d;
            pr = int'(wr_pr[i]);
            if (wr_valid[i] && pr != 0) begin
                b = pr % PRF_BANK_COUNT;
                d = (i - m_ptr[b] + PRF_WR_COUNT) % PRF_WR_COUNT;
                if (d < bestd[b]) begin bestd[b] = d; m_win[b] = i; end
            end
        end
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            int pr;
            pr = int'(wr_pr[i]);
            m_ready[i] = nRST && wr_valid[i] && (pr == 0 || m_win[pr % PRF_BANK_COUNT] == i);
        end
    endtask

    task automatic model_commit();
        if (!nRST) begin
            model_reset();
        end else begin
            int c;
            c = 0;
            for (int i = 0; i < PRF_WR_COUNT; i++)
                if (wr_valid[i] && !m_ready[i] && wr_pr[i] != '0) c++;
            m_perf = m_perf + c;
            if (m_perf > 64'hFFFF_FFFF) m_perf = 64'hFFFF_FFFF;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (m_win[b] >= 0) begin
                    m_wen[b]   = 1'b1;
                    m_wsrc[b]  = PRF_WR_COUNT'(1 << m_win[b]);
                    m_waddr[b] = int'(wr_pr[m_win[b]]) / PRF_BANK_COUNT;
                    m_wdata[b] = wr_data[m_win[b]];
                    m_ptr[b]   = (m_win[b] + 1) % PRF_WR_COUNT;
                end else begin
                    m_wen[b]  = 1'b0;
                    m_wsrc[b] = '0;
                end
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_reqs();
        for (int i = 0; i < PRF_WR_COUNT; i++) set_req(i, 4 * (i + 1), 32'hD0 + 32'(i));
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (wr_ready !== 8'h00) begin n_fail++; $display("FAIL reset_ready k=%0d got=%h exp=00", k, wr_ready); end
            n_checks++;
            if (bank_wen !== 4'b0000) begin n_fail++; $display("FAIL reset_wen k=%0d got=%b exp=0000", k, bank_wen); end
        end
        nRST = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 8'h01) begin n_fail++; $display("FAIL reset_first_ready got=%h exp=01", wr_ready); end
        @(posedge CLK); #1;
        n_checks++;
        if (bank_wen !== 4'b0001) begin n_fail++; $display("FAIL reset_first_wen got=%b exp=0001", bank_wen); end
        n_checks++;
        if (bank_wsrc[0] !== 8'h01 || bank_waddr[0] !== 5'd1 || bank_wdata[0] !== 32'hD0) begin
            n_fail++;
            $display("FAIL reset_first_write got src=%h addr=%0d data=%h exp src=01 addr=1 data=d0",
                     bank_wsrc[0], bank_waddr[0], bank_wdata[0]);
        end
    endtask

    task automatic test_no_conflict();
        apply_reset();
        set_req(0, 4, 32'hA0); set_req(1, 9, 32'hA1); set_req(2, 14, 32'hA2); set_req(3, 19, 32'hA3);
        #1;
        n_checks++;
        if (wr_ready !== 8'h0F) begin n_fail++; $display("FAIL noconf_ready got=%h exp=0f", wr_ready); end
        @(posedge CLK); #1;
        clear_reqs();
        n_checks++;
        if (bank_wen !== 4'b1111) begin n_fail++; $display("FAIL noconf_wen got=%b exp=1111", bank_wen); end
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            n_checks++;
            if (bank_waddr[b] !== 5'(b + 1) || bank_wdata[b] !== 32'hA0 + 32'(b) ||
                bank_wsrc[b] !== 8'(1 << b)) begin
                n_fail++;
                $display("FAIL noconf_bank%0d got addr=%0d data=%h src=%h exp addr=%0d data=%h src=%h",
                         b, bank_waddr[b], bank_wdata[b], bank_wsrc[b], b + 1, 32'hA0 + 32'(b), 8'(1 << b));
            end
        end
        @(posedge CLK); #1;
        n_checks++;
        if (bank_wen !== 4'b0000 || bank_wsrc !== '0) begin
            n_fail++; $display("FAIL noconf_oneshot got wen=%b src=%h exp wen=0000 src=0", bank_wen, bank_wsrc);
        end
    endtask

    task automatic test_round_robin();
        int order [3] = '{0, 3, 5};
        apply_reset();
        set_req(0, 8, 32'hB0); set_req(3, 8, 32'hB3); set_req(5, 8, 32'hB5);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (wr_ready !== 8'(1 << order[k])) begin
                n_fail++; $display("FAIL rr_ready k=%0d got=%h exp=%h", k, wr_ready, 8'(1 << order[k]));
            end
            @(posedge CLK); #1;
            n_checks++;
            if (bank_wen !== 4'b0001 || bank_wsrc[0] !== 8'(1 << order[k]) || bank_waddr[0] !== 5'd2) begin
                n_fail++;
                $display("FAIL rr_write k=%0d got wen=%b src=%h addr=%0d exp wen=0001 src=%h addr=2",
                         k, bank_wen, bank_wsrc[0], bank_waddr[0], 8'(1 << order[k]));
            end
            wr_valid[order[k]] = 1'b0;
        end
        // Pointer should now be 6: requester 6 beats requester 0.
        set_req(0, 4, 32'hC0); set_req(6, 12, 32'hC6);
        #1;
        n_checks++;
        if (wr_ready !== 8'h40) begin n_fail++; $display("FAIL rr_ptr6 got=%h exp=40", wr_ready); end
        clear_reqs();
    endtask

    task automatic test_wraparound();
        apply_reset();
        set_req(5, 1, 32'h55);
        #1;
        n_checks++;
        if (wr_ready !== 8'h20) begin n_fail++; $display("FAIL wrap_setup got=%h exp=20", wr_ready); end
        @(posedge CLK); #1;
        clear_reqs();
        set_req(1, 5, 32'hE1); set_req(7, 5, 32'hE7);
        #1;
        n_checks++;
        if (wr_ready !== 8'h80) begin n_fail++; $display("FAIL wrap_first got=%h exp=80", wr_ready); end
        @(posedge CLK); #1;
        n_checks++;
        if (bank_wsrc[1] !== 8'h80 || bank_waddr[1] !== 5'd1 || bank_wdata[1] !== 32'hE7) begin
            n_fail++; $display("FAIL wrap_first_write got src=%h addr=%0d data=%h exp src=80 addr=1 data=e7",
                               bank_wsrc[1], bank_waddr[1], bank_wdata[1]);
        end
        wr_valid[7] = 1'b0;
        #1;
        n_checks++;
        if (wr_ready !== 8'h02) begin n_fail++; $display("FAIL wrap_second got=%h exp=02", wr_ready); end
        @(posedge CLK); #1;
        n_checks++;
        if (bank_wsrc[1] !== 8'h02 || bank_wdata[1] !== 32'hE1) begin
            n_fail++; $display("FAIL wrap_second_write got src=%h data=%h exp src=02 data=e1", bank_wsrc[1], bank_wdata[1]);
        end
        clear_reqs();
        // Pointer should now be 2: requester 2 beats requester 1.
        set_req(1, 13, 32'hF1); set_req(2, 17, 32'hF2);
        #1;
        n_checks++;
        if (wr_ready !== 8'h04) begin n_fail++; $display("FAIL wrap_ptr2 got=%h exp=04", wr_ready); end
        clear_reqs();
    endtask

    task automatic test_pr0_drop();
        apply_reset();
        set_req(2, 0, 32'h22); set_req(4, 12, 32'h44);
        #1;
        n_checks++;
        if (wr_ready !== 8'h14) begin n_fail++; $display("FAIL pr0_ready got=%h exp=14", wr_ready); end
        @(posedge CLK); #1;
        n_checks++;
        if (bank_wen !== 4'b0001 || bank_wsrc[0] !== 8'h10 || bank_waddr[0] !== 5'd3 || bank_wdata[0] !== 32'h44) begin
            n_fail++; $display("FAIL pr0_write got wen=%b src=%h addr=%0d data=%h exp wen=0001 src=10 addr=3 data=44",
                               bank_wen, bank_wsrc[0], bank_waddr[0], bank_wdata[0]);
        end
        clear_reqs();
        set_req(2, 0, 32'h23);
        #1;
        n_checks++;
        if (wr_ready !== 8'h04) begin n_fail++; $display("FAIL pr0_alone_ready got=%h exp=04", wr_ready); end
        @(posedge CLK); #1;
        n_checks++;
        if (bank_wen !== 4'b0000 || bank_wsrc[0] !== 8'h00) begin
            n_fail++; $display("FAIL pr0_nowrite got wen=%b src=%h exp wen=0000 src=00", bank_wen, bank_wsrc[0]);
        end
        clear_reqs();
        // Pointer is still 5 if the PR0 writes left it alone: requester 6 beats 3.
        set_req(3, 8, 32'h33); set_req(6, 24, 32'h66);
        #1;
        n_checks++;
        if (wr_ready !== 8'h40) begin n_fail++; $display("FAIL pr0_ptr got=%h exp=40", wr_ready); end
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(1, 2, 32'h71); set_req(2, 6, 32'h72); set_req(3, 10, 32'h73);
        #1;
        n_checks++;
        if (wr_ready !== 8'h02) begin n_fail++; $display("FAIL rmid_ready got=%h exp=02", wr_ready); end
        @(posedge CLK); #1;
        n_checks++;
        if (bank_wen !== 4'b0100 || bank_wsrc[2] !== 8'h02) begin
            n_fail++; $display("FAIL rmid_first got wen=%b src=%h exp wen=0100 src=02", bank_wen, bank_wsrc[2]);
        end
        wr_valid[1] = 1'b0;
        nRST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (wr_ready !== 8'h00) begin n_fail++; $display("FAIL rmid_ready_rst k=%0d got=%h exp=00", k, wr_ready); end
            @(posedge CLK); #1;
            n_checks++;
            if (bank_wen !== 4'b0000 || bank_wsrc !== '0) begin
                n_fail++; $display("FAIL rmid_cleared k=%0d got wen=%b src=%h exp wen=0000 src=0", k, bank_wen, bank_wsrc);
            end
        end
`ifdef PRF_WR_ARB_PERF_EN
        n_checks++;
        if (perf_count !== 32'd0) begin n_fail++; $display("FAIL rmid_perf got=%0d exp=0", perf_count); end
`endif
        clear_reqs();
        nRST = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (bank_wen !== 4'b0000) begin n_fail++; $display("FAIL rmid_after got wen=%b exp=0000", bank_wen); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nRST = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (!wr_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, int'($urandom_range(0, PR_COUNT - 1)), $urandom);
                end
            end
            #1;
            model_eval();
            n_checks++;
            if (wr_ready !== m_ready) begin
                n_fail++; $display("FAIL rand_ready cyc=%0d got=%h exp=%h", cyc, wr_ready, m_ready);
            end
            @(posedge CLK);
            model_commit();
            #1;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                n_checks++;
                if (bank_wen[b] !== m_wen[b] || bank_wsrc[b] !== m_wsrc[b]) begin
                    n_fail++; $display("FAIL rand_bank%0d cyc=%0d got wen=%b src=%h exp wen=%b src=%h",
                                       b, cyc, bank_wen[b], bank_wsrc[b], m_wen[b], m_wsrc[b]);
                end else if (m_wen[b] &&
                             (bank_waddr[b] !== BANK_ADDR_W'(m_waddr[b]) || bank_wdata[b] !== m_wdata[b])) begin
                    n_fail++; $display("FAIL rand_data%0d cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                                       b, cyc, bank_waddr[b], bank_wdata[b], m_waddr[b], m_wdata[b]);
                end
            end
`ifdef PRF_WR_ARB_PERF_EN
            n_checks++;
            if (perf_count !== 32'(m_perf)) begin
                n_fail++; $display("FAIL rand_perf cyc=%0d got=%0d exp=%0d", cyc, perf_count, m_perf);
            end
`endif
            // Retire accepted requests; anything pending across reset is discarded.
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (m_ready[i] || !nRST) wr_valid[i] = 1'b0;
            end
        end
        nRST = 1'b1;
        clear_reqs();
    endtask

    initial begin
        nRST = 1'b0;
        clear_reqs();
        test_reset();
        test_no_conflict();
        test_round_robin();
        test_wraparound();
        test_pr0_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
